// File: rtl/vec_gather_pkg.sv
// ---------------------------------------------------------------------------
// vec_gather_pkg
//   Shared definitions for the vector gather block.
//   - Vector macros: float width, packed vector width and element select.
//     They are guarded so any file in the slice may rely on them without
//     redefining them.
//   - idxWidth(): width of a fill index for a vector of n elements, never
//     narrower than one bit so a single-element vector still has a legal
//     index register.
//   No ports; compile this file ahead of the files that import it.
// ---------------------------------------------------------------------------
`ifndef VG_VEC_MACROS
`define VG_VEC_MACROS
`define VG_FLOAT_WIDTH(ew, mw) (1 + (ew) + (mw))
`define VG_VEC_WIDTH(n, fw) ((n) * (fw))
`define VG_ELEM(vec, i, fw) vec[(i) * (fw) +: (fw)]
`endif

package vec_gather_pkg;

    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vec_gather.sv
// ---------------------------------------------------------------------------
// vec_gather
//   Collects scalar float elements (for example dot-product results) into a
//   packed vector of VEC_SIZE elements. A vector closes when its last slot is
//   filled or when an element arrives with in_last set; slots beyond the
//   closing element read as +0.0. Data bits are passed through untouched.
//
// Parameters
//   EXP_WIDTH, MANTISSA_WIDTH : float format, FW = 1 + EXP_WIDTH + MANTISSA_WIDTH
//   VEC_SIZE                  : elements per output vector (1..64)
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   scalar element offered
//   in_data    in   scalar element (FW bits)
//   in_last    in   element closes the current vector early
//   in_ready   out  element accepted when in_valid && in_ready
//   out_valid  out  assembled vector available
//   out_data   out  vector, element i at [i*FW +: FW]
//   out_ready  in   consumer takes vector when out_valid && out_ready
// ---------------------------------------------------------------------------
module vec_gather
    import vec_gather_pkg::*;
#(
    parameter int EXP_WIDTH      = 8,
    parameter int MANTISSA_WIDTH = 23,
    parameter int VEC_SIZE       = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic [`VG_FLOAT_WIDTH(EXP_WIDTH, MANTISSA_WIDTH)-1:0] in_data,
    input  logic in_last,
    output logic in_ready,
    output logic out_valid,
    output logic [`VG_VEC_WIDTH(VEC_SIZE, `VG_FLOAT_WIDTH(EXP_WIDTH, MANTISSA_WIDTH))-1:0] out_data,
    input  logic out_ready
);

    localparam int FW   = `VG_FLOAT_WIDTH(EXP_WIDTH, MANTISSA_WIDTH);
    localparam int VW   = `VG_VEC_WIDTH(VEC_SIZE, FW);
    localparam int IDXW = idxWidth(VEC_SIZE);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(VEC_SIZE - 1);

    logic [IDXW-1:0] idx_q, idx_d;
    logic [VW-1:0]   buf_q, buf_d;
    logic [VW-1:0]   out_q, out_d;
    logic            outValid_q, outValid_d;

    logic [VW-1:0]   merged;
    logic            closesVector;
    logic            accept;
    logic            outTake;

    // The buffer is cleared on every close, so every slot above the fill
    // index is already zero; writing the offered element into slot idx gives
    // the complete, zero-padded vector if this element closes it.
    always_comb begin
        merged = buf_q;
        `VG_ELEM(merged, int'(idx_q), FW) = in_data;
    end

    // Only an element that closes a vector needs the output register, so
    // back-pressure is applied to closing elements alone, and only while a
    // previous vector is still waiting for the consumer.
    assign closesVector = in_last || (idx_q == LAST_IDX);
    assign in_ready     = !(closesVector && outValid_q && !out_ready);
    assign accept       = in_valid && in_ready;
    assign outTake      = outValid_q && out_ready;

    // Next-state logic. A close in the same cycle as an output handshake
    // overrides the valid drop, so consecutive vectors leave no bubble.
    always_comb begin
        idx_d      = idx_q;
        buf_d      = buf_q;
        out_d      = out_q;
        outValid_d = outValid_q;
        if (outTake) begin
            outValid_d = 1'b0;
        end
        if (accept) begin
            if (closesVector) begin
                idx_d      = '0;
                buf_d      = '0;
                out_d      = merged;
                outValid_d = 1'b1;
            end else begin
                idx_d = idx_q + IDXW'(1);
                buf_d = merged;
            end
        end
    end

    // State registers; reset discards any partial and any held vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            buf_q      <= '0;
            out_q      <= '0;
            outValid_q <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            buf_q      <= buf_d;
            out_q      <= out_d;
            outValid_q <= outValid_d;
        end
    end

    assign out_valid = outValid_q;
    assign out_data  = out_q;

endmodule

// File: tb/tb_vec_gather.sv
// ---------------------------------------------------------------------------
// tb_vec_gather
//   Self-checking bench for vec_gather with the default float format and
//   VEC_SIZE = 4. Directed table rows, hand-written multi-cycle sequences and
//   a randomized run, all compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_vec_gather;

    localparam int EW = 8;
    localparam int MW = 23;
    localparam int VS = 4;
    localparam int FW = 32;
    localparam int VW = VS * FW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          inValid;
    logic [FW-1:0] inData;
    logic          inLast;
    logic          inReady;
    logic          outValid;
    logic [VW-1:0] outData;
    logic          outReady;

    int checks = 0;
    int errors = 0;

    // Reference model: elements of the vector being gathered, plus the one
    // vector (if any) currently offered to the consumer.
    logic [FW-1:0] curQ[$];
    bit            haveOut;
    logic [VW-1:0] outVec;

    // Expectations for the cycle being observed, produced by the model.
    logic          expReady;
    logic          expValid;
    logic [VW-1:0] expData;

    typedef struct {
        logic          v;
        logic [FW-1:0] d;
        logic          l;
        logic          r;
        logic          eReady;
        logic          eValid;
        logic [VW-1:0] eData;
    } vecRow_t;

    vecRow_t tbl[8];

    always #5 clk = ~clk;

    vec_gather #(
        .EXP_WIDTH(EW),
        .MANTISSA_WIDTH(MW),
        .VEC_SIZE(VS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(inValid),
        .in_data(inData),
        .in_last(inLast),
        .in_ready(inReady),
        .out_valid(outValid),
        .out_data(outData),
        .out_ready(outReady)
    );

    // Safety net so a broken design can never hang the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare the DUT's observable outputs against the given expectations.
    task automatic checkOutput(input string name, input logic eReady, input logic eValid,
                               input logic [VW-1:0] eData, input bit dataAlways);
        checks++;
        if (inReady !== eReady) begin
            errors++;
            $display("[TB] FAIL %s in_ready got %0b expected %0b", name, inReady, eReady);
        end
        checks++;
        if (outValid !== eValid) begin
            errors++;
            $display("[TB] FAIL %s out_valid got %0b expected %0b", name, outValid, eValid);
        end
        if (eValid || dataAlways) begin
            checks++;
            if (outData !== eData) begin
                errors++;
                $display("[TB] FAIL %s out_data got %h expected %h", name, outData, eData);
            end
        end
    endtask

    task automatic modelReset();
        curQ.delete();
        haveOut = 1'b0;
        outVec  = '0;
    endtask

    // Drive one cycle of inputs, then at the falling edge derive the model's
    // expectations for this cycle and advance the model past the coming edge.
    task automatic applyStimulus(input logic v, input logic [FW-1:0] d, input logic l, input logic r);
        inValid  = v;
        inData   = d;
        inLast   = l;
        outReady = r;
        @(negedge clk);
        expValid = haveOut;
        expData  = outVec;
        expReady = !((l || curQ.size() == VS - 1) && haveOut && !r);
        if (haveOut && r) haveOut = 1'b0;
        if (v && expReady) begin
            curQ.push_back(d);
            if (l || curQ.size() == VS) begin
                outVec = '0;
                foreach (curQ[i]) outVec[i*FW +: FW] = curQ[i];
                haveOut = 1'b1;
                curQ.delete();
            end
        end
    endtask

    task automatic endCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic modelCycle(input logic v, input logic [FW-1:0] d, input logic l, input logic r,
                              input string name);
        applyStimulus(v, d, l, r);
        checkOutput(name, expReady, expValid, expData, 1'b0);
        endCycle();
    endtask

    // Reset asserted and released away from the rising edge.
    task automatic doReset();
        inValid  = 1'b0;
        inData   = '0;
        inLast   = 1'b0;
        outReady = 1'b0;
        rst_n    = 1'b0;
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses;
        bit pulseVal;

        // Directed table: full vector, then a two-element vector closed by
        // in_last after a full one, which exposes any stale upper slots.
        tbl[0] = '{1'b1, 32'h3F800000, 1'b0, 1'b1, 1'b1, 1'b0, '0};
        tbl[1] = '{1'b1, 32'h40000000, 1'b0, 1'b1, 1'b1, 1'b0, '0};
        tbl[2] = '{1'b1, 32'h40400000, 1'b0, 1'b1, 1'b1, 1'b0, '0};
        tbl[3] = '{1'b1, 32'h40800000, 1'b0, 1'b1, 1'b1, 1'b0, '0};
        tbl[4] = '{1'b1, 32'h3F800000, 1'b0, 1'b1, 1'b1, 1'b1,
                   {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000}};
        tbl[5] = '{1'b1, 32'h40000000, 1'b1, 1'b1, 1'b1, 1'b0, '0};
        tbl[6] = '{1'b1, 32'h11111111, 1'b0, 1'b1, 1'b1, 1'b1,
                   {32'h00000000, 32'h00000000, 32'h40000000, 32'h3F800000}};
        tbl[7] = '{1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0, '0};

        // Reset state
        rst_n    = 1'b0;
        inValid  = 1'b0;
        inData   = '0;
        inLast   = 1'b0;
        outReady = 1'b0;
        modelReset();
        #12;
        checkOutput("reset_state", 1'b1, 1'b0, '0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        endCycle();

        $display("[TB] directed table");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r);
            checkOutput($sformatf("tbl%0d", i), tbl[i].eReady, tbl[i].eValid, tbl[i].eData, 1'b0);
            endCycle();
        end

        // Back-pressure: a pending vector blocks only the closing element.
        $display("[TB] back-pressure sequence");
        doReset();
        for (int k = 0; k < 4; k++) modelCycle(1'b1, 32'hA0 + k, 1'b0, 1'b1, "bp_fill");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 32'hB0 + k, 1'b0, 1'b0);
            checkOutput("bp_open", 1'b1, 1'b1, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b0);
            endCycle();
        end
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, 32'hB3, 1'b0, 1'b0);
            checkOutput("bp_stall", 1'b0, 1'b1, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b0);
            endCycle();
        end
        applyStimulus(1'b1, 32'hB3, 1'b0, 1'b1);
        checkOutput("bp_release", 1'b1, 1'b1, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b0);
        endCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("bp_newvec", 1'b1, 1'b1, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 1'b0);
        endCycle();

        // Continuous stream of 12 elements: pulses on cycles 5, 9 and 13.
        $display("[TB] streaming sequence");
        doReset();
        for (int c = 1; c <= 14; c++) begin
            applyStimulus(c <= 12, 32'h1000 + c, 1'b0, 1'b1);
            pulseVal = (c == 5 || c == 9 || c == 13);
            checkOutput($sformatf("stream_c%0d", c), 1'b1, pulseVal, expData, 1'b0);
            endCycle();
        end

        // Reset mid-vector while a vector is also held for the consumer.
        $display("[TB] mid-vector reset sequence");
        doReset();
        for (int k = 0; k < 4; k++) modelCycle(1'b1, 32'hF0 + k, 1'b0, 1'b0, "mr_full");
        for (int k = 0; k < 2; k++) modelCycle(1'b1, 32'hC0 + k, 1'b0, 1'b0, "mr_part");
        inValid = 1'b0;
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("mr_async", 1'b1, 1'b0, '0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        endCycle();
        for (int k = 0; k < 4; k++) modelCycle(1'b1, 32'hD0 + k, 1'b0, 1'b1, "mr_new");
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("mr_result", 1'b1, 1'b1, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 1'b0);
        endCycle();

        // in_last on the final slot produces one vector only.
        $display("[TB] last-on-final-slot sequence");
        doReset();
        pulses = 0;
        for (int k = 0; k < 9; k++) begin
            applyStimulus(k < 4, 32'hE0 + k, k == 3, 1'b1);
            if (outValid === 1'b1) pulses++;
            checkOutput("last_full", expReady, expValid, expData, 1'b0);
            endCycle();
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("[TB] FAIL last_pulses got %0d expected 1", pulses);
        end

        // Randomized traffic against the reference model.
        $display("[TB] random traffic");
        doReset();
        for (int n = 0; n < 400; n++) begin
            modelCycle(($urandom % 4) != 0, $urandom, ($urandom % 5) == 0,
                       ($urandom % 5) < 3, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
